buf_tdm_in: RTL and testbench
=============================

BUF_TDM_IN -- requirements
Module: buf_tdm_in

Interface
REQ-001 SHALL have parameter SLOT_WIDTH, default 32: bits per serial slot, 8..32.
REQ-002 SHALL have parameter AUDIO_WIDTH, default 24: stored bits per sample, AUDIO_WIDTH <= SLOT_WIDTH.
REQ-003 SHALL have parameter NUM_SLOTS, default 8: slots per frame, 2..16; fixed to 2 when MODE=0.
REQ-004 SHALL have parameter BUFFER_DEPTH, default 16: frame FIFO depth, power of two, >= 2.
REQ-005 SHALL have parameter MODE, default 1: 0 = I2S (frame start on lrclk falling edge), 1 = TDM (frame start on fsync rising edge).
REQ-006 SHALL have parameter DATA_DELAY, default 1: bclk edges between frame-start detection and slot-0 MSB, 0 or 1.
REQ-007 SHALL have parameter OVERWRITE_OLDEST, default 1: 1 = drop oldest frame on overflow, 0 = drop incoming frame.
REQ-008 sys_clk  in  1  single clock for all logic.
REQ-009 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-010 tdm_bclk  in  1  serial bit clock, asynchronous, sampled.
REQ-011 tdm_fsync  in  1  lrclk (MODE=0) or frame sync (MODE=1), asynchronous.
REQ-012 tdm_data  in  1  serial data, MSB first.
REQ-013 rd_en  in  1  pop head frame when frame_valid=1.
REQ-014 clr_overflow  in  1  clears overflow.
REQ-015 frame_out  out  [NUM_SLOTS][AUDIO_WIDTH]  head frame, element s = slot s.
REQ-016 frame_valid  out  1  FIFO non-empty.
REQ-017 fill_level  out  clog2(BUFFER_DEPTH)+1  frames stored.
REQ-018 frame_done  out  1  one-cycle pulse per completed frame, pushed or dropped.
REQ-019 frame_err  out  1  one-cycle pulse on framing error.
REQ-020 overflow  out  1  sticky; set on any overflow event.

Function
REQ-021 tdm_bclk, tdm_fsync and tdm_data SHALL each pass an identical 2-FF synchroniser; sys_clk >= 4x bclk frequency is required.
REQ-022 A bit SHALL be sampled in the sys_clk cycle a synchronised bclk rising edge is detected, using synchronised data and fsync of that cycle.
REQ-023 FSM states: HUNT, DELAY, RECV; reset state HUNT.
REQ-024 HUNT: on frame-start event, go to DELAY if DATA_DELAY=1, else RECV with the current bit taken as slot-0 MSB.
REQ-025 DELAY: next bclk edge -> RECV, that bit is slot-0 MSB.
REQ-026 RECV: bit counter 0..NUM_SLOTS*SLOT_WIDTH-1; slot bits 0..AUDIO_WIDTH-1 (MSB first) stored, remaining slot bits discarded.
REQ-027 After the last bit of the last slot: frame_done pulse and push in the next cycle (T+1); FSM returns to HUNT and accepts a start event on the very next bclk edge.
REQ-028 Frame-start event while in RECV or DELAY: frame_err pulse, partial frame discarded, new frame begins per REQ-024 (no push).
REQ-029 FIFO push and pop update fill_level on the same clock edge; frame_out/frame_valid reflect the new head in that cycle.
REQ-030 rd_en with fill_level=0 SHALL be ignored.
REQ-031 Push while full with rd_en=0: OVERWRITE_OLDEST=1 replaces oldest, head advances, fill_level stays BUFFER_DEPTH; OVERWRITE_OLDEST=0 drops new frame; overflow set in both cases.
REQ-032 Push and rd_en in same cycle when full: pop then push, fill_level unchanged, no overflow.
REQ-033 Pointers SHALL wrap modulo BUFFER_DEPTH with an extra MSB for full/empty.
REQ-034 clr_overflow clears overflow unless an overflow event occurs the same cycle (set wins).

Reset
REQ-035 sys_rst_n=0 SHALL asynchronously force: FSM HUNT, counters, pointers, FIFO storage and synchronisers to 0; frame_out=0, frame_valid=0, fill_level=0, frame_done=0, frame_err=0, overflow=0.
REQ-036 Reset mid-frame SHALL discard the partial frame; after release reception restarts at the next frame-start event.

Verification
REQ-037 TDM, defaults, 1 frame slots s=0x100000+s (top 24 of 32 bits) -> frame_done once, fill_level=1, frame_out[s]=0x100000+s.
REQ-038 MODE=0, NUM_SLOTS=2, L=0xABCDEF, R=0x123456 -> frame_out[0]=0xABCDEF, frame_out[1]=0x123456.
REQ-039 fsync pulse after 100 of 256 bits -> frame_err pulse, fill_level unchanged, following full frame stored correctly.
REQ-040 BUFFER_DEPTH=4, 5 frames F0..F4, no reads -> OVERWRITE_OLDEST=1: head=F1, fill=4, overflow=1; =0: head=F0, F4 lost, overflow=1.
REQ-041 Full FIFO, push coincident with rd_en -> fill_level=4, overflow stays 0; rd_en on empty -> fill_level stays 0.
REQ-042 sys_rst_n low mid-frame, released -> all outputs 0, first complete subsequent frame stored intact.

Source files
------------

// File: rtl/buf_tdm_in.sv
// Serial TDM / I2S capture into a frame FIFO.
// The serial pins are oversampled by sys_clk, which must run at 4x bclk or faster.
// Each completed frame is written as one FIFO entry, with one element per slot.
// For I2S use (MODE=0), instantiate with NUM_SLOTS=2.
module buf_tdm_in #(
  parameter int SLOT_WIDTH       = 32,
  parameter int AUDIO_WIDTH      = 24,
  parameter int NUM_SLOTS        = 8,
  parameter int BUFFER_DEPTH     = 16,
  parameter int MODE             = 1,
  parameter int DATA_DELAY       = 1,
  parameter int OVERWRITE_OLDEST = 1
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst_n,
  input  logic                                   tdm_bclk,
  input  logic                                   tdm_fsync,
  input  logic                                   tdm_data,
  input  logic                                   rd_en,
  input  logic                                   clr_overflow,
  output logic [NUM_SLOTS-1:0][AUDIO_WIDTH-1:0]  frame_out,
  output logic                                   frame_valid,
  output logic [$clog2(BUFFER_DEPTH):0]          fill_level,
  output logic                                   frame_done,
  output logic                                   frame_err,
  output logic                                   overflow
);

  localparam int PW  = $clog2(BUFFER_DEPTH);
  localparam int SLW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int BW  = $clog2(SLOT_WIDTH);
  localparam logic [SLW-1:0] SLOT_LAST = SLW'(NUM_SLOTS - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(SLOT_WIDTH - 1);
  localparam logic [BW:0]    AUD_BITS  = (BW+1)'(AUDIO_WIDTH);

  typedef enum logic [1:0] {HUNT, DELAY, RECV} state_t;
  localparam state_t START_ST = (DATA_DELAY == 1) ? DELAY : RECV;

  logic [1:0] bclk_sync, fs_sync, dat_sync;
  logic       bclk_q, fs_prev;
  logic       bit_stb, fs, dat;

  state_t                               state;
  logic [SLW-1:0]                       slot_idx, cur_slot;
  logic [BW-1:0]                        bit_idx, cur_bit;
  logic [NUM_SLOTS-1:0][AUDIO_WIDTH-1:0] wr_frame;
  logic                                 start_evt, err_evt, take, frame_end;

  logic [NUM_SLOTS-1:0][AUDIO_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, ovf_evt, ovw_evt, wr_ok;

  // Two-flop synchronisers on every serial pin, plus the previous bclk level for edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bclk_sync <= '0;
      fs_sync   <= '0;
      dat_sync  <= '0;
      bclk_q    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], tdm_bclk};
      fs_sync   <= {fs_sync[0], tdm_fsync};
      dat_sync  <= {dat_sync[0], tdm_data};
      bclk_q    <= bclk_sync[1];
    end
  end

  assign bit_stb = bclk_sync[1] & ~bclk_q;
  assign fs      = fs_sync[1];
  assign dat     = dat_sync[1];

  // Decode the start event and decide whether the current bit belongs to a frame.
  always_comb begin
    start_evt = bit_stb && ((MODE == 1) ? (fs & ~fs_prev) : (~fs & fs_prev));
    err_evt   = start_evt && (state != HUNT);
    take      = 1'b0;
    cur_slot  = slot_idx;
    cur_bit   = bit_idx;
    if (start_evt) begin
      cur_slot = '0;
      cur_bit  = '0;
      take     = (DATA_DELAY == 0);
    end else if (bit_stb && state != HUNT) begin
      take = 1'b1;
    end
    frame_end = take && !start_evt && (state == RECV) &&
                (slot_idx == SLOT_LAST) && (bit_idx == BIT_LAST);
  end

  // Receive FSM: shift audio bits into the assembly frame and track the slot/bit position.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= HUNT;
      slot_idx   <= '0;
      bit_idx    <= '0;
      wr_frame   <= '0;
      fs_prev    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      frame_err  <= err_evt;
      if (bit_stb) fs_prev <= fs;
      if (take) begin
        if ({1'b0, cur_bit} < AUD_BITS)
          wr_frame[cur_slot] <= {wr_frame[cur_slot][AUDIO_WIDTH-2:0], dat};
        if (cur_bit == BIT_LAST) begin
          bit_idx  <= '0;
          slot_idx <= cur_slot + SLW'(1);
        end else begin
          bit_idx  <= cur_bit + BW'(1);
          slot_idx <= cur_slot;
        end
      end else if (start_evt) begin
        slot_idx <= '0;
        bit_idx  <= '0;
      end
      if (start_evt) begin
        state <= START_ST;
      end else if (frame_end) begin
        state    <= HUNT;
        slot_idx <= '0;
        bit_idx  <= '0;
      end else if (take && state == DELAY) begin
        state <= RECV;
      end
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (fill_level == (PW+1)'(BUFFER_DEPTH));
  assign pop     = rd_en && !empty;
  // A full FIFO with no simultaneous pop is the only overflow condition.
  assign ovf_evt = frame_done && full && !pop;
  assign ovw_evt = ovf_evt && (OVERWRITE_OLDEST == 1);
  assign wr_ok   = frame_done && (!ovf_evt || ovw_evt);

  // Frame FIFO: pop is applied before push, so a full FIFO that pops in the same cycle accepts the push.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < BUFFER_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop || ovw_evt) rd_ptr <= rd_ptr + (PW+1)'(1);
      if (wr_ok) begin
        mem[wr_ptr[PW-1:0]] <= wr_frame;
        wr_ptr              <= wr_ptr + (PW+1)'(1);
      end
      if (ovf_evt)           overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign frame_out   = mem[rd_ptr[PW-1:0]];
  assign frame_valid = !empty;
  assign fill_level  = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_buf_tdm_in.sv
// Scoreboard bench for buf_tdm_in.
// Three instances are used:
//   a: TDM, depth 4, overwrite the oldest frame on overflow
//   b: TDM, depth 4, drop the incoming frame on overflow
//   c: I2S, two slots, default depth
module tb_buf_tdm_in;
  typedef logic [7:0][23:0] frame_t;

  logic sys_clk = 0, sys_rst_n = 0, tdm_bclk = 0;
  logic fs_t = 0, dat_t = 0, fs_i = 1, dat_i = 0;
  logic rd_en = 0, clr_overflow = 0;

  frame_t fo_a, fo_b;
  logic [1:0][23:0] fo_c;
  logic [2:0] fl_a, fl_b;
  logic [4:0] fl_c;
  logic [2:0] fv, fd, fe, ov;

  frame_t     fo_v [3];
  logic [4:0] fl_v [3];

  always #5 sys_clk = ~sys_clk;

  buf_tdm_in #(.BUFFER_DEPTH(4), .OVERWRITE_OLDEST(1)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tdm_bclk(tdm_bclk), .tdm_fsync(fs_t),
    .tdm_data(dat_t), .rd_en(rd_en), .clr_overflow(clr_overflow), .frame_out(fo_a),
    .frame_valid(fv[0]), .fill_level(fl_a), .frame_done(fd[0]), .frame_err(fe[0]),
    .overflow(ov[0]));
  buf_tdm_in #(.BUFFER_DEPTH(4), .OVERWRITE_OLDEST(0)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tdm_bclk(tdm_bclk), .tdm_fsync(fs_t),
    .tdm_data(dat_t), .rd_en(rd_en), .clr_overflow(clr_overflow), .frame_out(fo_b),
    .frame_valid(fv[1]), .fill_level(fl_b), .frame_done(fd[1]), .frame_err(fe[1]),
    .overflow(ov[1]));
  buf_tdm_in #(.MODE(0), .NUM_SLOTS(2)) dut_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tdm_bclk(tdm_bclk), .tdm_fsync(fs_i),
    .tdm_data(dat_i), .rd_en(rd_en), .clr_overflow(clr_overflow), .frame_out(fo_c),
    .frame_valid(fv[2]), .fill_level(fl_c), .frame_done(fd[2]), .frame_err(fe[2]),
    .overflow(ov[2]));

  assign fo_v[0] = fo_a;
  assign fo_v[1] = fo_b;
  assign fo_v[2] = {144'b0, fo_c};
  assign fl_v[0] = {2'b0, fl_a};
  assign fl_v[1] = {2'b0, fl_b};
  assign fl_v[2] = fl_c;

  // Reference model: per-instance ordered list of stored frames.
  int     depth [3] = '{4, 4, 16};
  bit     ovw   [3] = '{1, 0, 1};
  frame_t mm    [3][16];
  int     mcnt  [3] = '{0, 0, 0};
  bit     movf  [3] = '{0, 0, 0};
  bit     dirty [3] = '{0, 0, 0};
  int     errcnt[3] = '{0, 0, 0};
  int     exp_err[3] = '{0, 0, 0};
  frame_t pend0[$], pend1[$], pend2[$];

  int n_cmp = 0, n_bad = 0;
  int rd_budget = 0, rd_used = 0, arm_req = 0, arm_used = 0;

  task automatic chk(input string name, input int k, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  // Monitor: compare DUT against the model after every event, then apply this cycle's events.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mcnt[k] = 0; movf[k] = 0; dirty[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        frame_t f;
        bit have, pop, oe;
        if (dirty[k]) begin
          chk("fill", k, 192'(fl_v[k]), 192'(mcnt[k]));
          chk("valid", k, 192'(fv[k]), 192'(mcnt[k] > 0));
          chk("overflow", k, 192'(ov[k]), 192'(movf[k]));
          if (mcnt[k] > 0) chk("head", k, fo_v[k], mm[k][0]);
        end
        have = 0;
        f = '0;
        if (fd[k]) begin
          case (k)
            0: if (pend0.size() > 0) begin f = pend0.pop_front(); have = 1; end
            1: if (pend1.size() > 0) begin f = pend1.pop_front(); have = 1; end
            default: if (pend2.size() > 0) begin f = pend2.pop_front(); have = 1; end
          endcase
          if (!have) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_done dut%0d: got unexpected pulse expected none", k);
          end
        end
        if (fe[k]) errcnt[k]++;
        pop = rd_en && mcnt[k] > 0;
        if (pop) begin
          for (int i = 0; i < 15; i++) mm[k][i] = mm[k][i+1];
          mcnt[k]--;
        end
        oe = 0;
        if (have) begin
          if (mcnt[k] < depth[k]) begin
            mm[k][mcnt[k]] = f; mcnt[k]++;
          end else begin
            oe = 1;
            if (ovw[k]) begin
              for (int i = 0; i < 15; i++) mm[k][i] = mm[k][i+1];
              mm[k][mcnt[k]-1] = f;
            end
          end
        end
        if (oe) movf[k] = 1;
        else if (clr_overflow) movf[k] = 0;
        dirty[k] = rd_en || fd[k] || clr_overflow;
      end
    end
  end

  // Reader: random pops within the granted budget, and an armed pop coincident with frame_done.
  always @(posedge sys_clk) begin
    #1;
    rd_en = 0;
    if (arm_used < arm_req && fd[0]) begin
      rd_en = 1; arm_used++;
    end else if (rd_used < rd_budget && $urandom_range(0, 3) == 0) begin
      rd_en = 1; rd_used++;
    end
  end

  task automatic bit_cyc(input bit fs, input bit d, input bit i2s);
    if (i2s) begin fs_i = fs; dat_i = d; end
    else begin fs_t = fs; dat_t = d; end
    #40 tdm_bclk = 1;
    #40 tdm_bclk = 0;
  endtask

  task automatic send_tdm(input frame_t f, input int nbits);
    bit_cyc(1, 0, 0);
    for (int b = 0; b < nbits; b++) begin
      int s, p;
      s = b / 32; p = b % 32;
      bit_cyc(0, (p < 24) ? f[s][23-p] : 1'($urandom), 0);
    end
  endtask

  task automatic tdm_frame(input frame_t f);
    pend0.push_back(f);
    pend1.push_back(f);
    send_tdm(f, 256);
  endtask

  task automatic i2s_frame(input logic [23:0] l, input logic [23:0] r);
    frame_t f;
    f = '0; f[0] = l; f[1] = r;
    pend2.push_back(f);
    bit_cyc(0, 0, 1);
    for (int b = 0; b < 64; b++) begin
      int s, p;
      s = b / 32; p = b % 32;
      bit_cyc(s == 1, (p < 24) ? f[s][23-p] : 1'($urandom), 1);
    end
    bit_cyc(1, 0, 1);
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int s = 0; s < 8; s++) f[s] = 24'($urandom);
    return f;
  endfunction

  task automatic idle(input int n, input bit i2s);
    repeat (n) bit_cyc(i2s, 0, i2s);
  endtask

  task automatic drain();
    int t;
    t = 0;
    rd_budget = rd_used + 64;
    while (t < 3000 && (mcnt[0] != 0 || mcnt[1] != 0 || mcnt[2] != 0)) begin
      @(posedge sys_clk); t++;
    end
    if (t >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got frames left after %0d cycles expected empty", t);
    end
    @(posedge sys_clk);
    rd_budget = rd_used;
    #2;
  endtask

  task automatic chk_zero();
    for (int k = 0; k < 3; k++) begin
      chk("rst fill", k, 192'(fl_v[k]), 192'(0));
      chk("rst valid", k, 192'(fv[k]), 192'(0));
      chk("rst done", k, 192'(fd[k]), 192'(0));
      chk("rst err", k, 192'(fe[k]), 192'(0));
      chk("rst overflow", k, 192'(ov[k]), 192'(0));
      chk("rst frame_out", k, fo_v[k], 192'(0));
    end
  endtask

  initial begin
    frame_t f, f0, f1;
    #2;
    sys_rst_n = 0;
    #100 chk_zero();
    sys_rst_n = 1;
    #100 idle(2, 0);

    // Known single frame, slot s carries 0x100000+s.
    for (int s = 0; s < 8; s++) f[s] = 24'h100000 + 24'(s);
    tdm_frame(f);
    idle(4, 0);
    chk("single fill", 0, 192'(fl_a), 192'(1));
    chk("single head", 0, fo_a, f);
    drain();

    // Frame sync after 100 bits aborts the partial frame; the next frame is intact.
    send_tdm(rand_frame(), 100);
    exp_err[0]++; exp_err[1]++;
    tdm_frame(rand_frame());
    idle(4, 0);
    drain();

    // Five frames into depth 4 without reads.
    f0 = rand_frame(); f1 = rand_frame();
    tdm_frame(f0); tdm_frame(f1);
    for (int i = 0; i < 3; i++) tdm_frame(rand_frame());
    idle(4, 0);
    chk("ovw fill", 0, 192'(fl_a), 192'(4));
    chk("ovw head", 0, fo_a, f1);
    chk("ovw overflow", 0, 192'(ov[0]), 192'(1));
    chk("drop fill", 1, 192'(fl_b), 192'(4));
    chk("drop head", 1, fo_b, f0);
    chk("drop overflow", 1, 192'(ov[1]), 192'(1));
    @(posedge sys_clk); #2 clr_overflow = 1;
    @(posedge sys_clk); #2 clr_overflow = 0;

    // Push coincident with a pop on a full FIFO.
    arm_req++;
    tdm_frame(rand_frame());
    idle(4, 0);
    chk("coinc fill", 0, 192'(fl_a), 192'(4));
    chk("coinc overflow", 0, 192'(ov[0]), 192'(0));
    chk("coinc fill", 1, 192'(fl_b), 192'(4));
    chk("coinc overflow", 1, 192'(ov[1]), 192'(0));
    drain();
    rd_budget = rd_used + 8;
    repeat (80) @(posedge sys_clk);
    rd_budget = rd_used;
    #2 chk("empty read fill", 0, 192'(fl_a), 192'(0));

    // Random frames with random gaps and concurrent random reads.
    rd_budget = rd_used + 100000;
    for (int i = 0; i < 6; i++) begin
      idle($urandom_range(0, 3), 0);
      tdm_frame(rand_frame());
    end
    idle(4, 0);
    drain();

    // I2S: left and right words.
    i2s_frame(24'hABCDEF, 24'h123456);
    idle(2, 1);
    chk("i2s left", 2, 192'(fo_c[0]), 192'(24'hABCDEF));
    chk("i2s right", 2, 192'(fo_c[1]), 192'(24'h123456));
    for (int i = 0; i < 3; i++) i2s_frame(24'($urandom), 24'($urandom));
    idle(2, 1);
    drain();

    // Reset in the middle of a frame; the next frame must be stored intact.
    send_tdm(rand_frame(), 60);
    sys_rst_n = 0;
    #30 chk_zero();
    sys_rst_n = 1;
    #20 idle(2, 0);
    f = rand_frame();
    tdm_frame(f);
    idle(4, 0);
    chk("post-rst fill", 0, 192'(fl_a), 192'(1));
    chk("post-rst head", 0, fo_a, f);
    drain();

    for (int k = 0; k < 3; k++) chk("frame_err count", k, 192'(errcnt[k]), 192'(exp_err[k]));
    chk("pending", 0, 192'(pend0.size()), 192'(0));
    chk("pending", 1, 192'(pend1.size()), 192'(0));
    chk("pending", 2, 192'(pend2.size()), 192'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
